// File: rtl/acc_bank.sv
// acc_bank: DEPTH x WIDTH accumulator bank with LOAD/ADD/SUB/CLEAR ops,
// a valid/ready request port and a one-deep registered result port.
// Optional feature: define ACC_SAT_EN to clamp ADD carry / SUB borrow
// results (all-ones / zero) and report it on out_sat.

// One accumulator entry; written only on the accepting edge when selected.
module acc_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Entry storage, cleared by the bank reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end

endmodule

module acc_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [SW-1:0]    in_sel,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [SW-1:0]    out_sel,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_sat
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic [SW-1:0]    sel;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             sat;
  } rsp_t;

  logic [DEPTH-1:0][WIDTH-1:0] acc_q;
  logic [DEPTH-1:0]            acc_we;
  logic                        accept;

  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             sat;

  rsp_t rsp_d;
  rsp_t rsp_q;

  // Single-deep output register: a new request fits whenever the slot is
  // empty or being drained in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Entry array; only the selected entry sees a write enable.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign acc_we[i] = accept && (in_sel == SW'(i));
    acc_entry #(.WIDTH(WIDTH)) u_ent (
      .clock (clock),
      .reset (reset),
      .we    (acc_we[i]),
      .d     (res),
      .q     (acc_q[i])
    );
  end

  // Unclamped arithmetic and carry/borrow/overflow for the selected entry.
  always_comb begin
    cur   = acc_q[in_sel];
    sum   = {1'b0, cur} + {1'b0, in};
    dif   = {1'b0, cur} - {1'b0, in};
    raw   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (in_op)
      OP_LOAD: raw = in;
      OP_ADD: begin
        raw   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (cur[WIDTH-1] == in[WIDTH-1]) && (raw[WIDTH-1] != cur[WIDTH-1]);
      end
      OP_SUB: begin
        raw   = dif[WIDTH-1:0];
        carry = dif[WIDTH];
        ovf   = (cur[WIDTH-1] != in[WIDTH-1]) && (raw[WIDTH-1] != cur[WIDTH-1]);
      end
      OP_CLEAR: raw = '0;
      default:  raw = '0;
    endcase
  end

`ifdef ACC_SAT_EN
  // Clamp on unsigned overflow/underflow; flags keep the raw arithmetic.
  always_comb begin
    res = raw;
    sat = 1'b0;
    if (in_op == OP_ADD && carry) begin
      res = '1;
      sat = 1'b1;
    end else if (in_op == OP_SUB && carry) begin
      res = '0;
      sat = 1'b1;
    end
  end
`else
  assign res = raw;
  assign sat = 1'b0;
`endif

  // Response word captured alongside the entry update.
  always_comb begin
    rsp_d       = '0;
    rsp_d.value = res;
    rsp_d.sel   = in_sel;
    rsp_d.carry = carry;
    rsp_d.ovf   = ovf;
    rsp_d.zero  = (res == '0);
    rsp_d.sat   = sat;
  end

  // Output register: reload on accept, drop valid on drain, hold on stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_q     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      rsp_q     <= rsp_d;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out       = rsp_q.value;
  assign out_sel   = rsp_q.sel;
  assign out_carry = rsp_q.carry;
  assign out_ovf   = rsp_q.ovf;
  assign out_zero  = rsp_q.zero;
  assign out_sat   = rsp_q.sat;

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank (WIDTH 8, DEPTH 4). Driver pushes hand-computed
// responses into a queue; a monitor pops and compares on every consumed output.
module tb_acc_bank;

  localparam logic [1:0] LD = 2'b00, AD = 2'b01, SB = 2'b10, CL = 2'b11;

  typedef struct packed {
    logic [7:0] v;
    logic [1:0] sel;
    logic       c, o, z, s;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [1:0] in_sel = 2'b00;
  logic [7:0] in = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out;
  logic [1:0] out_sel;
  logic       out_carry, out_ovf, out_zero, out_sat;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   w;

  acc_bank #(.WIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sel(in_sel), .in(in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_sel(out_sel),
    .out_carry(out_carry), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_sat(out_sat)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(logic [7:0] v, logic [1:0] sel,
                              logic c, logic o, logic z, logic s);
    exp_t e;
    e.v = v; e.sel = sel; e.c = c; e.o = o; e.z = z; e.s = s;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with in_valid low.
  task automatic send(logic [1:0] op, logic [1:0] sel, logic [7:0] d,
                      exp_t e, bit push, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1; in_op = op; in_sel = sel; in = d;
    while (!ok && waits < 20) begin
      #2;
      if (in_ready) ok = 1'b1;
      else begin
        waits++;
        @(negedge clock);
      end
    end
    if (ok) begin
      @(posedge clock);
      if (push) sb.push_back(e);
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout sel %0d got in_ready 0 exp 1", sel);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Send with expected response and require immediate acceptance.
  task automatic go(string name, logic [1:0] op, logic [1:0] sel,
                    logic [7:0] d, exp_t e);
    int wt;
    send(op, sel, d, e, 1'b1, wt);
    chk({name, "_nowait"}, wt, 0);
  endtask

  // Monitor: compare every consumed output against the scoreboard head.
  always @(negedge clock) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got out %h sel %0d exp no output", out, out_sel);
      end else begin
        mon_e = sb.pop_front();
        if ({out, out_sel, out_carry, out_ovf, out_zero, out_sat} !== mon_e) begin
          errors++;
          $display("FAIL sb_out got v=%h sel=%0d c=%b o=%b z=%b s=%b exp v=%h sel=%0d c=%b o=%b z=%b s=%b",
                   out, out_sel, out_carry, out_ovf, out_zero, out_sat,
                   mon_e.v, mon_e.sel, mon_e.c, mon_e.o, mon_e.z, mon_e.s);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Request presented during reset must be dropped.
    in_valid = 1'b1; in_op = LD; in_sel = 2'd0; in = 8'h55;
    repeat (2) @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_flags", {out_carry, out_ovf, out_zero, out_sat}, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clock);

    // LOAD / ADD on entry 2, then other entries read back 0.
    go("ld12", LD, 2'd2, 8'h12, mk(8'h12, 2'd2, 0, 0, 0, 0));
    go("add05", AD, 2'd2, 8'h05, mk(8'h17, 2'd2, 0, 0, 0, 0));
    go("rd0", AD, 2'd0, 8'h00, mk(8'h00, 2'd0, 0, 0, 1, 0));
    go("rd1", AD, 2'd1, 8'h00, mk(8'h00, 2'd1, 0, 0, 1, 0));
    go("rd3", AD, 2'd3, 8'h00, mk(8'h00, 2'd3, 0, 0, 1, 0));

    // Wrap / saturate on ADD.
    go("ldff", LD, 2'd0, 8'hFF, mk(8'hFF, 2'd0, 0, 0, 0, 0));
`ifdef ACC_SAT_EN
    go("addwrap", AD, 2'd0, 8'h01, mk(8'hFF, 2'd0, 1, 0, 0, 1));
`else
    go("addwrap", AD, 2'd0, 8'h01, mk(8'h00, 2'd0, 1, 0, 1, 0));
`endif

    // Signed overflow on ADD, borrow on SUB.
    go("ld7f", LD, 2'd1, 8'h7F, mk(8'h7F, 2'd1, 0, 0, 0, 0));
    go("addovf", AD, 2'd1, 8'h01, mk(8'h80, 2'd1, 0, 1, 0, 0));
    go("ld10", LD, 2'd1, 8'h10, mk(8'h10, 2'd1, 0, 0, 0, 0));
`ifdef ACC_SAT_EN
    go("subbrw", SB, 2'd1, 8'h90, mk(8'h00, 2'd1, 1, 1, 1, 1));
`else
    go("subbrw", SB, 2'd1, 8'h90, mk(8'h80, 2'd1, 1, 1, 0, 0));
`endif
    go("ld30", LD, 2'd0, 8'h30, mk(8'h30, 2'd0, 0, 0, 0, 0));
    go("sub10", SB, 2'd0, 8'h10, mk(8'h20, 2'd0, 0, 0, 0, 0));
    go("ld80", LD, 2'd0, 8'h80, mk(8'h80, 2'd0, 0, 0, 0, 0));
    go("subovf", SB, 2'd0, 8'h01, mk(8'h7F, 2'd0, 0, 1, 0, 0));

    // Back-to-back on entry 3.
    go("b2b1", AD, 2'd3, 8'h01, mk(8'h01, 2'd3, 0, 0, 0, 0));
    go("b2b2", AD, 2'd3, 8'h01, mk(8'h02, 2'd3, 0, 0, 0, 0));
    go("b2b3", AD, 2'd3, 8'h01, mk(8'h03, 2'd3, 0, 0, 0, 0));
    go("b2b4", AD, 2'd3, 8'h01, mk(8'h04, 2'd3, 0, 0, 0, 0));

    // Stall: consumer blocked for 3 cycles while a request waits.
    @(negedge clock);
    out_ready = 1'b0;
    go("ld33", LD, 2'd2, 8'h33, mk(8'h33, 2'd2, 0, 0, 0, 0));
    in_valid = 1'b1; in_op = AD; in_sel = 2'd2; in = 8'h01;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out", {out_valid, out}, {1'b1, 8'h33});
      @(negedge clock);
    end
    out_ready = 1'b1;
    #2;
    chk("release_in_ready", in_ready, 1);
    @(posedge clock);
    sb.push_back(mk(8'h34, 2'd2, 0, 0, 0, 0));
    @(negedge clock);
    in_valid = 1'b0;
    go("after_stall", AD, 2'd2, 8'h01, mk(8'h35, 2'd2, 0, 0, 0, 0));

    // Reset mid-stream with a held result.
    @(negedge clock);
    out_ready = 1'b0;
    send(LD, 2'd1, 8'hAA, mk(8'hAA, 2'd1, 0, 0, 0, 0), 1'b0, w);
    chk("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", {out, out_sel}, 0);
    chk("mid_rst_flags", {out_carry, out_ovf, out_zero, out_sat}, 0);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    go("post0", AD, 2'd0, 8'h00, mk(8'h00, 2'd0, 0, 0, 1, 0));
    go("post1", AD, 2'd1, 8'h00, mk(8'h00, 2'd1, 0, 0, 1, 0));
    go("post2", AD, 2'd2, 8'h00, mk(8'h00, 2'd2, 0, 0, 1, 0));
    go("post3", AD, 2'd3, 8'h00, mk(8'h00, 2'd3, 0, 0, 1, 0));
    go("ld05", LD, 2'd1, 8'h05, mk(8'h05, 2'd1, 0, 0, 0, 0));
    go("clr1", CL, 2'd1, 8'h5A, mk(8'h00, 2'd1, 0, 0, 1, 0));

    repeat (3) @(negedge clock);
    #2;
    chk("sb_empty", sb.size(), 0);
    chk("idle_valid", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised multi-entry accumulator bank: DEPTH independent WIDTH-bit accumulator registers, each updated by a selectable operation (load, add, subtract, clear) with the ALU-side operand. It has a valid/ready request port and a one-deep registered result port carrying the new value plus carry/overflow/zero flags. It sits between the ALU result bus and the ALU operand input, replacing the single 8-bit load-only accumulator.

## Interface
- WIDTH, 8, accumulator and operand width in bits (≥2)
- DEPTH, 4, number of accumulator entries (≥2, power of two); SW = log2(DEPTH)
- clock  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high; clears all entries, flags and the output register
- in_valid  input  1  request present
- in_ready  output  1  bank can accept a request this cycle
- in_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- in_sel  input  SW  target entry
- in  input  WIDTH  operand
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer takes result this cycle
- out  output  WIDTH  new value of the updated entry
- out_sel  output  SW  entry that was updated
- out_carry  output  1  ADD carry-out / SUB borrow
- out_ovf  output  1  signed overflow (two's complement)
- out_zero  output  1  out == 0
- out_sat  output  1  result was clamped (0 when ACC_SAT_EN undefined)

## Operation
- Request accepted on a rising edge with in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational; one-deep output register, full throughput when consumer always ready).
- On acceptance, in the same edge: entry[in_sel] ← result; output register ← {result, in_sel, flags}; out_valid ← 1.
- Otherwise, if out_ready, out_valid ← 0. Output fields hold value while out_valid && !out_ready.
- LOAD: result = in; carry = ovf = 0.
- ADD: {carry, result} = entry + in ((WIDTH+1)-bit sum); ovf = operand MSBs equal and differ from result MSB.
- SUB: result = entry − in mod 2^WIDTH; carry = 1 when in > entry (unsigned borrow); ovf = operand MSBs differ and result MSB differs from entry MSB.
- CLEAR: result = 0; in ignored; carry = ovf = 0.
- zero computed on final (post-saturation) result.
- Entries not selected are untouched. No operation without acceptance; in_op/in_sel/in are don't-care when in_valid = 0.

## Timing
- Reset (async assert, any time): all entries = 0, out_valid = 0, out = 0, out_sel = 0, all flags 0; in_ready = 1 after reset. A request in the reset cycle is dropped.
- Latency: result visible on out one clock after acceptance.
- Back-to-back ops on the same entry: second op uses value written by the first (no hazard; entry register updated on the accepting edge).
- Simultaneous accept and output drain: allowed; out register reloaded with the new result, out_valid stays 1.
- Stall: out_valid && !out_ready → in_ready = 0; entries and output hold.
- Wrap: ADD of 0xFF + 0x01 (WIDTH 8) → 0x00, carry 1, zero 1 (without saturation).

## Configuration
- ACC_SAT_EN defined: ADD with carry → result = all-ones, out_sat = 1; SUB with borrow → result = 0, out_sat = 1; carry/ovf still report the unclamped arithmetic; entry stores clamped value.
- ACC_SAT_EN undefined: modular wrap, out_sat tied 0, no clamp logic.

## Test plan
- Reset then LOAD 0x12 into entry 2, ADD 0x05 to entry 2 -> out 0x12 then 0x17, out_sel 2, flags 0; entries 0,1,3 read back 0 via ADD 0.
- ADD 0xFF + 0x01 on entry 0 -> without ACC_SAT_EN out 0x00, carry 1, zero 1; with it out 0xFF, sat 1, carry 1.
- LOAD 0x7F, ADD 0x01 -> out 0x80, ovf 1, carry 0; SUB 0x90 from 0x10 -> 0x80, borrow 1 (0x00, sat 1 with ACC_SAT_EN).
- Hold out_ready 0 for 3 cycles with in_valid 1 -> in_ready 0, out stable, entries unchanged; release -> one accept per cycle resumes, no request lost or duplicated.
- Back-to-back ADD 0x01 ×4 on entry 3 every cycle with out_ready 1 -> outs 1,2,3,4 on consecutive cycles.
- Assert reset mid-stream with out_valid 1 -> out_valid, out, flags 0 immediately; all entries 0; CLEAR on entry 1 afterwards -> out 0, zero 1.
